mem_stage: RTL and testbench

- DLX pipeline memory-access stage. Sits between the EX/MEM pipeline register and the write-back stage.
- Drives loads and stores to data memory over a req/ack handshake. Generates big-endian byte enables and store-lane replication.
- Stalls the upstream pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register, which carries every field write-back consumes. Load data is passed raw; write-back does the sizing and sign extension.

---
 rtl/dlx_mem_pkg.sv | 33 +++
 rtl/store_align.sv | 41 ++++
 rtl/mem_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlx_mem_pkg
// Purpose  : Shared encodings for the DLX memory-access stage: access sizes,
//            FSM states, big-endian byte-enable patterns and an address helper.
// Revision : 1.0 - initial release
// ============================================================================
package dlx_mem_pkg;

  // Access size encodings carried on DSize (bit 0 is the MSB)
  localparam logic [0:1] DSZ_WORD = 2'b00;
  localparam logic [0:1] DSZ_HALF = 2'b01;
  localparam logic [0:1] DSZ_BYTE = 2'b10;

  // Memory-access FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // Byte-enable patterns; index 0 is the most significant byte lane
  localparam logic [0:3] c_BE_ALL     = 4'b1111;
  localparam logic [0:3] c_BE_HI_HALF = 4'b1100;
  localparam logic [0:3] c_BE_LO_HALF = 4'b0011;
  localparam logic [0:3] c_BE_BYTE0   = 4'b1000;

  // Clears the two byte-offset bits to form the bus word address
  function automatic logic [0:31] word_align(input logic [0:31] addr);
    return {addr[0:29], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
// Module   : store_align
// Purpose  : Combinational big-endian byte-enable generation and store-lane
//            replication from access size and the low two address bits.
// Revision : 1.0 - initial release
// ============================================================================
module store_align
  import dlx_mem_pkg::*;
(
  input  logic [0:1]  i_dsize,
  input  logic [0:1]  i_addr_lo,
  input  logic [0:31] i_store_data,
  output logic [0:3]  o_be,
  output logic [0:31] o_wdata
);

  // Select lanes and replicate the right-justified source into every lane
  always_comb begin
    o_be    = c_BE_ALL;
    o_wdata = i_store_data;
    case (i_dsize)
      DSZ_BYTE: begin
        o_be    = c_BE_BYTE0 >> i_addr_lo;
        o_wdata = {4{i_store_data[24:31]}};
      end
      DSZ_HALF: begin
        // Only addr[30] picks the half; addr[31] is ignored here
        o_be    = i_addr_lo[0] ? c_BE_LO_HALF : c_BE_HI_HALF;
        o_wdata = {2{i_store_data[16:31]}};
      end
      default: begin
        // Word (and the unused 11 code) touches all four lanes
        o_be    = c_BE_ALL;
        o_wdata = i_store_data;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : DLX memory-access stage. Issues loads/stores over a req/ack bus,
//            stalls upstream while an access is outstanding, abandons an
//            access after TIMEOUT_CYCLES with bus_err, and owns MEM/WB.
//            Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word
//            accesses are trapped (misalign_exc) instead of being issued.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import dlx_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [0:31] nextPC_in,
  input  logic [0:4]  destReg_in,
  input  logic [0:31] aluResult_in,
  input  logic [0:31] storeData_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [0:1]  DSize_in,
  input  logic        loadSign_in,
  input  logic        PCtoReg_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        FPRegWrite_in,
  input  logic        mul_in,
  input  logic [0:4]  fDestReg_in,
  input  logic [0:63] fbusW_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [0:31] dmem_addr,
  output logic [0:3]  dmem_be,
  output logic [0:31] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [0:31] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [0:31] nextPC_out,
  output logic [0:4]  destReg_out,
  output logic [0:31] aluResult_out,
  output logic [0:31] dataOut_out,
  output logic        PCtoReg_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        loadSign_out,
  output logic [0:1]  DSize_out,
  output logic [0:4]  fDestReg_out,
  output logic [0:63] fbusW_out,
  output logic        FPRegWrite_out,
  output logic        mul_out,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_exc
`endif
);

  localparam int              c_CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t         r_state;
  logic [c_CNT_W-1:0] r_wait_cnt;

  logic        w_memop;
  logic        w_misalign;
  logic        w_issue;
  logic        w_timeout;
  logic        w_mewb_load;
  logic        w_wb_valid;
  logic        w_regwrite;
  logic        w_fpregwrite;
  logic [0:31] w_data_out;
  logic [0:3]  w_be;
  logic [0:31] w_wdata;

  store_align u_store_align (
    .i_dsize      (DSize_in),
    .i_addr_lo    (aluResult_in[30:31]),
    .i_store_data (storeData_in),
    .o_be         (w_be),
    .o_wdata      (w_wdata)
  );

  assign w_memop = ex_valid & (MemRead_in | MemWrite_in);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_memop &
                      (((DSize_in == DSZ_HALF) & aluResult_in[31]) |
                       ((DSize_in == DSZ_WORD) & (aluResult_in[30:31] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue   = w_memop & ~w_misalign;
  assign w_timeout = (r_state == ST_WAIT) & ~dmem_ack & (r_wait_cnt == c_CNT_LAST);

  // Upstream is held while an access is being issued or is still outstanding;
  // the timeout cycle releases it so the abandoned instruction moves on
  assign stall = (r_state == ST_IDLE) ? w_issue : (~dmem_ack & ~w_timeout);

  // MEM/WB advances every IDLE cycle and when an outstanding access resolves
  assign w_mewb_load = (r_state == ST_IDLE) | dmem_ack | w_timeout;

  // Decide the control fields that MEM/WB takes on this edge
  always_comb begin
    w_wb_valid   = 1'b0;
    w_regwrite   = 1'b0;
    w_fpregwrite = 1'b0;
    w_data_out   = '0;
    if (r_state == ST_IDLE) begin
      // An issuing memop leaves a bubble; everything else passes straight on
      if (!w_issue) begin
        w_wb_valid   = ex_valid;
        w_regwrite   = RegWrite_in & ex_valid & ~w_misalign;
        w_fpregwrite = FPRegWrite_in & ex_valid & ~w_misalign;
      end
    end else if (dmem_ack) begin
      // EX/MEM is stalled, so its fields still describe the pending access
      w_wb_valid   = 1'b1;
      w_regwrite   = RegWrite_in;
      w_fpregwrite = FPRegWrite_in;
      w_data_out   = MemRead_in ? dmem_rdata : 32'h0;
    end else if (w_timeout) begin
      // Abandoned access retires with its register writes suppressed
      w_wb_valid = 1'b1;
    end
  end

  // Access FSM: issues the bus request, counts wait cycles, reports errors
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      bus_err    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_in;
            dmem_addr  <= word_align(aluResult_in);
            dmem_be    <= w_be;
            dmem_wdata <= w_wdata;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_exc <= w_misalign;
`endif
        end
        ST_WAIT: begin
          // Address, enables and write data stay put until the access ends
          if (dmem_ack) begin
            r_state  <= ST_IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
          end else if (w_timeout) begin
            r_state  <= ST_IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            bus_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid       <= 1'b0;
      nextPC_out     <= '0;
      destReg_out    <= '0;
      aluResult_out  <= '0;
      dataOut_out    <= '0;
      PCtoReg_out    <= 1'b0;
      RegWrite_out   <= 1'b0;
      MemToReg_out   <= 1'b0;
      loadSign_out   <= 1'b0;
      DSize_out      <= '0;
      fDestReg_out   <= '0;
      fbusW_out      <= '0;
      FPRegWrite_out <= 1'b0;
      mul_out        <= 1'b0;
    end else if (w_mewb_load) begin
      wb_valid       <= w_wb_valid;
      nextPC_out     <= nextPC_in;
      destReg_out    <= destReg_in;
      aluResult_out  <= aluResult_in;
      dataOut_out    <= w_data_out;
      PCtoReg_out    <= PCtoReg_in;
      RegWrite_out   <= w_regwrite;
      MemToReg_out   <= MemToReg_in;
      loadSign_out   <= loadSign_in;
      DSize_out      <= DSize_in;
      fDestReg_out   <= fDestReg_in;
      fbusW_out      <= fbusW_in;
      FPRegWrite_out <= w_fpregwrite;
      mul_out        <= mul_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage (TIMEOUT_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic [0:31] nextPC_in;
  logic [0:4]  destReg_in;
  logic [0:31] aluResult_in;
  logic [0:31] storeData_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [0:1]  DSize_in;
  logic        loadSign_in;
  logic        PCtoReg_in;
  logic        RegWrite_in;
  logic        MemToReg_in;
  logic        FPRegWrite_in;
  logic        mul_in;
  logic [0:4]  fDestReg_in;
  logic [0:63] fbusW_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [0:31] dmem_addr;
  logic [0:3]  dmem_be;
  logic [0:31] dmem_wdata;
  logic        dmem_ack;
  logic [0:31] dmem_rdata;
  logic        stall;
  logic        wb_valid;
  logic [0:31] nextPC_out;
  logic [0:4]  destReg_out;
  logic [0:31] aluResult_out;
  logic [0:31] dataOut_out;
  logic        PCtoReg_out;
  logic        RegWrite_out;
  logic        MemToReg_out;
  logic        loadSign_out;
  logic [0:1]  DSize_out;
  logic [0:4]  fDestReg_out;
  logic [0:63] fbusW_out;
  logic        FPRegWrite_out;
  logic        mul_out;
  logic        bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  int total = 0;
  int bad   = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid),
    .nextPC_in(nextPC_in), .destReg_in(destReg_in),
    .aluResult_in(aluResult_in), .storeData_in(storeData_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .DSize_in(DSize_in),
    .loadSign_in(loadSign_in), .PCtoReg_in(PCtoReg_in),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .FPRegWrite_in(FPRegWrite_in), .mul_in(mul_in),
    .fDestReg_in(fDestReg_in), .fbusW_in(fbusW_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .wb_valid(wb_valid),
    .nextPC_out(nextPC_out), .destReg_out(destReg_out),
    .aluResult_out(aluResult_out), .dataOut_out(dataOut_out),
    .PCtoReg_out(PCtoReg_out), .RegWrite_out(RegWrite_out),
    .MemToReg_out(MemToReg_out), .loadSign_out(loadSign_out),
    .DSize_out(DSize_out), .fDestReg_out(fDestReg_out),
    .fbusW_out(fbusW_out), .FPRegWrite_out(FPRegWrite_out),
    .mul_out(mul_out), .bus_err(bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_exc(misalign_exc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; nextPC_in = 0; destReg_in = 0; aluResult_in = 0;
    storeData_in = 0; MemRead_in = 0; MemWrite_in = 0; DSize_in = 2'b00;
    loadSign_in = 0; PCtoReg_in = 0; RegWrite_in = 0; MemToReg_in = 0;
    FPRegWrite_in = 0; mul_in = 0; fDestReg_in = 0; fbusW_in = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    #1;
    // Reset state
    chk("rst_req", dmem_req, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall", stall, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Plain ALU op passes straight through in one cycle
    ex_valid = 1; aluResult_in = 32'h10; RegWrite_in = 1; destReg_in = 5;
    nextPC_in = 32'h44;
    #1 chk("add_stall", stall, 0);
    tick();
    chk("add_alu", aluResult_out, 32'h10);
    chk("add_wb_valid", wb_valid, 1);
    chk("add_regwrite", RegWrite_out, 1);
    chk("add_dest", destReg_out, 5);
    chk("add_nextpc", nextPC_out, 32'h44);
    chk("add_data", dataOut_out, 0);
    chk("add_req", dmem_req, 0);

    // Byte store at 0x103, ack in the first WAIT cycle
    clear_inputs();
    ex_valid = 1; MemWrite_in = 1; DSize_in = 2'b10; aluResult_in = 32'h103;
    storeData_in = 32'hAB;
    #1 chk("sb_stall_issue", stall, 1);
    tick();
    chk("sb_req", dmem_req, 1);
    chk("sb_we", dmem_we, 1);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_be", dmem_be, 4'b0001);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_bubble", wb_valid, 0);
    dmem_ack = 1;
    #1 chk("sb_stall_ack", stall, 0);
    tick();
    chk("sb_req_drop", dmem_req, 0);
    chk("sb_wb_valid", wb_valid, 1);
    chk("sb_data", dataOut_out, 0);
    chk("sb_alu", aluResult_out, 32'h103);

    // Half load at 0x202, ack in the 4th WAIT cycle (coincides with timeout)
    clear_inputs();
    ex_valid = 1; MemRead_in = 1; DSize_in = 2'b01; aluResult_in = 32'h202;
    RegWrite_in = 1; MemToReg_in = 1; destReg_in = 7; dmem_rdata = 32'h1234ABCD;
    #1 chk("lh_stall_issue", stall, 1);
    tick();
    chk("lh_req", dmem_req, 1);
    chk("lh_we", dmem_we, 0);
    chk("lh_be", dmem_be, 4'b0011);
    chk("lh_addr", dmem_addr, 32'h200);
    for (int i = 0; i < 3; i++) begin
      chk("lh_stall_wait", stall, 1);
      chk("lh_bubble_wait", wb_valid, 0);
      tick();
      chk("lh_addr_stable", dmem_addr, 32'h200);
    end
    dmem_ack = 1;
    #1 chk("lh_stall_ack", stall, 0);
    tick();
    chk("lh_data", dataOut_out, 32'h1234ABCD);
    chk("lh_wb_valid", wb_valid, 1);
    chk("lh_regwrite", RegWrite_out, 1);
    chk("lh_dest", destReg_out, 7);
    chk("lh_no_bus_err", bus_err, 0);
    chk("lh_req_drop", dmem_req, 0);
    clear_inputs();
    tick();
    chk("lh_wb_once", wb_valid, 0);

    // Word load at 0x300, never acknowledged -> timeout after 4 WAIT cycles
    ex_valid = 1; MemRead_in = 1; DSize_in = 2'b00; aluResult_in = 32'h300;
    RegWrite_in = 1;
    tick();
    chk("to_req", dmem_req, 1);
    chk("to_be", dmem_be, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      chk("to_stall_wait", stall, 1);
      chk("to_no_err", bus_err, 0);
      tick();
    end
    chk("to_stall_last", stall, 0);
    tick();
    chk("to_bus_err", bus_err, 1);
    chk("to_req_drop", dmem_req, 0);
    chk("to_regwrite", RegWrite_out, 0);
    clear_inputs();
    tick();
    chk("to_err_pulse", bus_err, 0);
    chk("to_idle_stall", stall, 0);
    chk("to_idle_req", dmem_req, 0);

    // Reset asserted in the middle of WAIT
    ex_valid = 1; MemWrite_in = 1; DSize_in = 2'b00; aluResult_in = 32'h400;
    storeData_in = 32'hDEADBEEF;
    tick();
    chk("rw_req", dmem_req, 1);
    chk("rw_wdata", dmem_wdata, 32'hDEADBEEF);
    #2 reset_n = 1'b0;
    #1;
    chk("rw_req_async", dmem_req, 0);
    chk("rw_wdata_rst", dmem_wdata, 0);
    chk("rw_addr_rst", dmem_addr, 0);
    chk("rw_wb_rst", wb_valid, 0);
    tick();
    clear_inputs();
    reset_n = 1'b1;
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    tick();
    chk("rw_late_ack_req", dmem_req, 0);
    chk("rw_late_ack_wb", wb_valid, 0);
    chk("rw_late_ack_data", dataOut_out, 0);
    chk("rw_late_ack_err", bus_err, 0);
    dmem_ack = 0;

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load traps without a bus request
    clear_inputs();
    ex_valid = 1; MemRead_in = 1; DSize_in = 2'b00; aluResult_in = 32'h101;
    RegWrite_in = 1;
    #1 chk("mis_stall", stall, 0);
    tick();
    chk("mis_req", dmem_req, 0);
    chk("mis_exc", misalign_exc, 1);
    chk("mis_regwrite", RegWrite_out, 0);
    clear_inputs();
    tick();
    chk("mis_exc_pulse", misalign_exc, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
